// File: rtl/vend_change_dispenser.sv
// Change dispenser: pays out CHANGE_AMT greedily as quarters/dimes/nickels from local inventory; optional DISPENSE_TIMEOUT_EN.
// Latency: START to first coin request 2 cycles, ACK to next coin request 3 cycles, zero amount DONE after 2 cycles.
// Backpressure: each coin request is held until ACK (or, with DISPENSE_TIMEOUT_EN, until TIMEOUT_CYC cycles elapse).
module vend_change_dispenser #(
    parameter int AMT_W       = 6,
    parameter int INV_W       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [AMT_W-1:0] CHANGE_AMT,
    input  logic             LOAD,
    input  logic [INV_W-1:0] Q_IN,
    input  logic [INV_W-1:0] D_IN,
    input  logic [INV_W-1:0] N_IN,
    input  logic             ACK,
    output logic             COIN_Q,
    output logic             COIN_D,
    output logic             COIN_N,
    output logic             BUSY,
    output logic             DONE,
    output logic             SHORT,
    output logic [AMT_W-1:0] REMAIN,
    output logic [INV_W-1:0] Q_CNT,
    output logic [INV_W-1:0] D_CNT,
    output logic [INV_W-1:0] N_CNT
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_EJECT  = 3'd2,
        S_GAP    = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t           state_r, state_nxt;
    logic [2:0]       coin_r, coin_nxt;      // {quarter, dime, nickel}, one-hot or zero
    logic [AMT_W-1:0] rem_r, rem_nxt;
    logic [INV_W-1:0] q_r, q_nxt, d_r, d_nxt, n_r, n_nxt;
    logic             short_r, short_nxt;
    logic             busy_r, done_r;

`ifdef DISPENSE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_r;
    logic             tmo_hit;

    assign tmo_hit = (tmo_r == TMO_W'(TIMEOUT_CYC - 1));

    // Counts cycles spent in EJECT; any other state re-arms it for the next coin.
    always_ff @(posedge CLK) begin
        if (RST || state_r != S_EJECT) begin
            tmo_r <= '0;
        end else begin
            tmo_r <= tmo_r + TMO_W'(1);
        end
    end
`endif

    always_comb begin
        state_nxt = state_r;
        coin_nxt  = coin_r;
        rem_nxt   = rem_r;
        q_nxt     = q_r;
        d_nxt     = d_r;
        n_nxt     = n_r;
        short_nxt = short_r;
        case (state_r)
            S_IDLE: begin
                if (LOAD) begin
                    q_nxt = Q_IN;
                    d_nxt = D_IN;
                    n_nxt = N_IN;
                end
                if (START) begin
                    rem_nxt   = CHANGE_AMT;
                    short_nxt = 1'b0;
                    state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                // Greedy pick; the thresholds keep REMAIN from underflowing.
                if (rem_r == '0) begin
                    state_nxt = S_FIN;
                end else if (rem_r >= AMT_W'(5) && q_r != '0) begin
                    coin_nxt  = 3'b100;
                    state_nxt = S_EJECT;
                end else if (rem_r >= AMT_W'(2) && d_r != '0) begin
                    coin_nxt  = 3'b010;
                    state_nxt = S_EJECT;
                end else if (n_r != '0) begin
                    coin_nxt  = 3'b001;
                    state_nxt = S_EJECT;
                end else begin
                    short_nxt = 1'b1;
                    state_nxt = S_FIN;
                end
            end
            S_EJECT: begin
                if (ACK) begin
                    coin_nxt  = 3'b000;
                    state_nxt = S_GAP;
                    if (coin_r[2]) begin
                        q_nxt   = q_r - INV_W'(1);
                        rem_nxt = rem_r - AMT_W'(5);
                    end else if (coin_r[1]) begin
                        d_nxt   = d_r - INV_W'(1);
                        rem_nxt = rem_r - AMT_W'(2);
                    end else begin
                        n_nxt   = n_r - INV_W'(1);
                        rem_nxt = rem_r - AMT_W'(1);
                    end
                end
`ifdef DISPENSE_TIMEOUT_EN
                else if (tmo_hit) begin
                    coin_nxt  = 3'b000;
                    short_nxt = 1'b1;
                    state_nxt = S_FIN;
                end
`endif
            end
            S_GAP:    state_nxt = S_SELECT;
            S_FIN:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= S_IDLE;
            coin_r  <= 3'b000;
            rem_r   <= '0;
            q_r     <= '0;
            d_r     <= '0;
            n_r     <= '0;
            short_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            coin_r  <= coin_nxt;
            rem_r   <= rem_nxt;
            q_r     <= q_nxt;
            d_r     <= d_nxt;
            n_r     <= n_nxt;
            short_r <= short_nxt;
            busy_r  <= (state_nxt != S_IDLE);
            done_r  <= (state_nxt == S_FIN);
        end
    end

    assign COIN_Q = coin_r[2];
    assign COIN_D = coin_r[1];
    assign COIN_N = coin_r[0];
    assign BUSY   = busy_r;
    assign DONE   = done_r;
    assign SHORT  = short_r;
    assign REMAIN = rem_r;
    assign Q_CNT  = q_r;
    assign D_CNT  = d_r;
    assign N_CNT  = n_r;

endmodule
